// File: rtl/bulls_cows_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bulls_cows_pkg
//  Description : Shared types and digit helpers for the Bulls & Cows game.
//  Revision    : 1.0  initial release
// ============================================================================
package bulls_cows_pkg;

  // Game controller states; the encoding is visible to the display logic.
  typedef enum logic [2:0] {
    READ_S1 = 3'd0,
    READ_S2 = 3'd1,
    GUESS   = 3'd2,
    SCORE   = 3'd3,
    SHOW    = 3'd4,
    WIN     = 3'd5,
    DRAW    = 3'd6
  } state_t;

  // Widest entry vector the helpers accept (N_DIGITS*DIGIT_W must fit).
  localparam int VEC_W = 64;

  // Extract digit i (DW bits wide) from a zero-extended entry vector.
  function automatic logic [31:0] digit_at(input logic [VEC_W-1:0] vec,
                                           input int i, input int dw);
    logic [VEC_W-1:0] mask;
    logic [VEC_W-1:0] sh;
    mask = (VEC_W'(1) << dw) - VEC_W'(1);
    sh   = (vec >> (i * dw)) & mask;
    return sh[31:0];
  endfunction

  // An entry is legal when its N digits are pairwise distinct and in range.
  function automatic logic entry_valid(input logic [VEC_W-1:0] vec,
                                       input int n, input int dw,
                                       input int maxd);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (digit_at(vec, i, dw) > 32'(maxd)) ok = 1'b0;
      for (int j = i + 1; j < n; j++) begin
        if (digit_at(vec, i, dw) == digit_at(vec, j, dw)) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bc_entry_check.sv
`default_nettype none
// ============================================================================
//  Module      : bc_entry_check
//  Description : Combinational legality check of a switch entry (distinct
//                digits, each no larger than MAX_DIGIT). Also used by the
//                display block for live feedback while the user types.
//  Revision    : 1.0  initial release
// ============================================================================
module bc_entry_check
  import bulls_cows_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_DIGIT = 9
) (
  input  logic [N_DIGITS*DIGIT_W-1:0] sw_i,
  output logic                        valid_o
);

  logic [VEC_W-1:0] vec;

  // Zero-extend the entry into the helper width and evaluate legality.
  always_comb begin
    vec                          = '0;
    vec[N_DIGITS*DIGIT_W-1:0]    = sw_i;
    valid_o = entry_valid(vec, N_DIGITS, DIGIT_W, MAX_DIGIT);
  end

endmodule
`default_nettype wire

// File: rtl/bulls_cows_game.sv
`default_nettype none
// ============================================================================
//  Module      : bulls_cows_game
//  Description : Two-player Bulls & Cows controller. Captures both secrets,
//                alternates guesses, scores one digit per cycle and tracks
//                tries with win / draw detection.
//  Revision    : 1.0  initial release
// ============================================================================
module bulls_cows_game
  import bulls_cows_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_DIGIT = 9,
  parameter int MAX_TRIES = 10
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 confirm,
  input  logic [N_DIGITS*DIGIT_W-1:0]          SW,
  output logic [2:0]                           state_o,
  output logic                                 cur_player,
  output logic [$clog2(N_DIGITS+1)-1:0]        bulls,
  output logic [$clog2(N_DIGITS+1)-1:0]        cows,
  output logic                                 result_valid,
  output logic                                 entry_err,
  output logic [$clog2(MAX_TRIES+1)-1:0]       tries_p1,
  output logic [$clog2(MAX_TRIES+1)-1:0]       tries_p2,
  output logic                                 win,
  output logic                                 winner,
  output logic                                 draw
);

  localparam int W     = N_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(N_DIGITS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = $clog2(N_DIGITS);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] ALL_BULLS = CNT_W'(N_DIGITS);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

  state_t             state_q, state_d;
  logic               cur_player_q, cur_player_d;
  logic [W-1:0]       secret1_q, secret1_d;
  logic [W-1:0]       secret2_q, secret2_d;
  logic [W-1:0]       guess_q, guess_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   bulls_q, bulls_d;
  logic [CNT_W-1:0]   cows_q, cows_d;
  logic [TRY_W-1:0]   tries1_q, tries1_d;
  logic [TRY_W-1:0]   tries2_q, tries2_d;
  logic               entry_err_q, entry_err_d;
  logic               confirm_q;

  logic               cf_edge;
  logic               entry_ok;
  logic [VEC_W-1:0]   guess_vec;
  logic [VEC_W-1:0]   target_vec;
  logic [31:0]        guess_dig;
  logic               hit_bull;
  logic               hit_any;
  logic               hit_cow;

  assign cf_edge = confirm & ~confirm_q;

  bc_entry_check #(
    .N_DIGITS  (N_DIGITS),
    .DIGIT_W   (DIGIT_W),
    .MAX_DIGIT (MAX_DIGIT)
  ) u_entry_check (
    .sw_i    (SW),
    .valid_o (entry_ok)
  );

  // Compare the current guess digit against the opponent's secret.
  always_comb begin
    guess_vec            = '0;
    target_vec           = '0;
    guess_vec[W-1:0]     = guess_q;
    target_vec[W-1:0]    = cur_player_q ? secret1_q : secret2_q;
    guess_dig            = digit_at(guess_vec, int'(idx_q), DIGIT_W);
    hit_bull = (guess_dig == digit_at(target_vec, int'(idx_q), DIGIT_W));
    hit_any  = 1'b0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (guess_dig == digit_at(target_vec, j, DIGIT_W)) hit_any = 1'b1;
    end
    // Secrets have distinct digits, so a non-bull match is exactly one cow.
    hit_cow = hit_any & ~hit_bull;
  end

  // Next-state and datapath update for the game controller.
  always_comb begin
    state_d      = state_q;
    cur_player_d = cur_player_q;
    secret1_d    = secret1_q;
    secret2_d    = secret2_q;
    guess_d      = guess_q;
    idx_d        = idx_q;
    bulls_d      = bulls_q;
    cows_d       = cows_q;
    tries1_d     = tries1_q;
    tries2_d     = tries2_q;
    entry_err_d  = 1'b0;

    case (state_q)
      READ_S1: begin
        if (cf_edge) begin
          if (entry_ok) begin
            secret1_d = SW;
            state_d   = READ_S2;
          end else begin
            entry_err_d = 1'b1;
          end
        end
      end

      READ_S2: begin
        if (cf_edge) begin
          if (entry_ok) begin
            secret2_d    = SW;
            cur_player_d = 1'b0;
            state_d      = GUESS;
          end else begin
            entry_err_d = 1'b1;
          end
        end
      end

      GUESS: begin
        if (cf_edge) begin
          if (entry_ok) begin
            guess_d = SW;
            bulls_d = '0;
            cows_d  = '0;
            idx_d   = '0;
            if (!cur_player_q) begin
              if (tries1_q != TRY_LIMIT) tries1_d = tries1_q + 1'b1;
            end else begin
              if (tries2_q != TRY_LIMIT) tries2_d = tries2_q + 1'b1;
            end
            state_d = SCORE;
          end else begin
            entry_err_d = 1'b1;
          end
        end
      end

      SCORE: begin
        // Confirm edges are deliberately ignored while scoring.
        bulls_d = bulls_q + CNT_W'(hit_bull);
        cows_d  = cows_q + CNT_W'(hit_cow);
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = (bulls_d == ALL_BULLS) ? WIN : SHOW;
        end
      end

      SHOW: begin
        if (cf_edge) begin
          if ((tries1_q == TRY_LIMIT) && (tries2_q == TRY_LIMIT)) begin
            state_d = DRAW;
          end else begin
            cur_player_d = ~cur_player_q;
            state_d      = GUESS;
          end
        end
      end

      default: begin
        // WIN and DRAW hold until reset.
      end
    endcase
  end

  // State register; reset overrides every other event in the cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= READ_S1;
      cur_player_q <= 1'b0;
      secret1_q    <= '0;
      secret2_q    <= '0;
      guess_q      <= '0;
      idx_q        <= '0;
      bulls_q      <= '0;
      cows_q       <= '0;
      tries1_q     <= '0;
      tries2_q     <= '0;
      entry_err_q  <= 1'b0;
      confirm_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_player_q <= cur_player_d;
      secret1_q    <= secret1_d;
      secret2_q    <= secret2_d;
      guess_q      <= guess_d;
      idx_q        <= idx_d;
      bulls_q      <= bulls_d;
      cows_q       <= cows_d;
      tries1_q     <= tries1_d;
      tries2_q     <= tries2_d;
      entry_err_q  <= entry_err_d;
      confirm_q    <= confirm;
    end
  end

  assign state_o      = state_q;
  assign cur_player   = cur_player_q;
  assign bulls        = bulls_q;
  assign cows         = cows_q;
  assign result_valid = (state_q == SHOW) || (state_q == WIN);
  assign entry_err    = entry_err_q;
  assign tries_p1     = tries1_q;
  assign tries_p2     = tries2_q;
  assign win          = (state_q == WIN);
  assign winner       = (state_q == WIN) & cur_player_q;
  assign draw         = (state_q == DRAW);

endmodule
`default_nettype wire

// File: tb/tb_bulls_cows_game.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bulls_cows_game
//  Description : Self-checking bench for bulls_cows_game (4 digits, 2 tries).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bulls_cows_game;
  import bulls_cows_pkg::*;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int MD = 9;
  localparam int MT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        confirm;
  logic [15:0] SW;
  logic [2:0]  state_o;
  logic        cur_player;
  logic [2:0]  bulls, cows;
  logic        result_valid, entry_err;
  logic [1:0]  tries_p1, tries_p2;
  logic        win, winner, draw;

  int n_vec = 0;
  int n_bad = 0;

  bulls_cows_game #(.N_DIGITS(ND), .DIGIT_W(DW), .MAX_DIGIT(MD), .MAX_TRIES(MT)) dut (
    .clock(clock), .reset(reset), .confirm(confirm), .SW(SW),
    .state_o(state_o), .cur_player(cur_player), .bulls(bulls), .cows(cows),
    .result_valid(result_valid), .entry_err(entry_err),
    .tries_p1(tries_p1), .tries_p2(tries_p2),
    .win(win), .winner(winner), .draw(draw)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] sw;
    bit          ok;
    int          b;
    int          c;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; confirm = 1'b0; SW = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string name);
    chk({name, ".state"}, state_o, READ_S1);
    chk({name, ".player"}, cur_player, 0);
    chk({name, ".bulls"}, bulls, 0);
    chk({name, ".cows"}, cows, 0);
    chk({name, ".rv"}, result_valid, 0);
    chk({name, ".err"}, entry_err, 0);
    chk({name, ".t1"}, tries_p1, 0);
    chk({name, ".t2"}, tries_p2, 0);
    chk({name, ".win"}, win, 0);
    chk({name, ".winner"}, winner, 0);
    chk({name, ".draw"}, draw, 0);
  endtask

  // One clean confirm press: edge, then release. Checks the error pulse shape.
  task automatic press(input logic [15:0] sw, input bit exp_err, input string name);
    SW = sw; confirm = 1'b1;
    tick();
    chk({name, ".err"}, entry_err, exp_err);
    confirm = 1'b0;
    tick();
    chk({name, ".err_clr"}, entry_err, 0);
  endtask

  // After press() two edges have passed; result appears N_DIGITS+1 edges in.
  task automatic score_wait(input string name);
    tick(); tick();
    chk({name, ".rv_early"}, result_valid, 0);
    tick();
    chk({name, ".rv"}, result_valid, 1);
  endtask

  // ---------------- reference model (rules-level) ----------------
  function automatic bit m_valid(input logic [15:0] v);
    int cnt[16] = '{default: 0};
    for (int i = 0; i < ND; i++) begin
      int d;
      d = int'(v[i*DW +: DW]);
      if (d > MD) return 1'b0;
      cnt[d]++;
      if (cnt[d] > 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_score(input logic [15:0] g, input logic [15:0] t, output int b, output int c);
    bit present[16] = '{default: 1'b0};
    int hits;
    b = 0; hits = 0;
    for (int i = 0; i < ND; i++) present[t[i*DW +: DW]] = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (g[i*DW +: DW] == t[i*DW +: DW]) b++;
      if (present[g[i*DW +: DW]]) hits++;
    end
    c = hits - b;
  endtask

  function automatic logic [15:0] rand_perm();
    int d[10];
    int k, t;
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) d[i] = i;
    for (int i = 0; i < ND; i++) begin
      k = int'($urandom_range(9, i));
      t = d[i]; d[i] = d[k]; d[k] = t;
      v[i*DW +: DW] = 4'(d[i]);
    end
    return v;
  endfunction

  vec_t tbl[10];

  initial begin
    reset = 1'b1; confirm = 1'b0; SW = '0;

    // ---------------- main sequence ----------------
    do_reset();
    check_idle("reset");
    press(16'h1123, 1'b1, "dup_s1");
    chk("dup_s1.state", state_o, READ_S1);
    press(16'h12A4, 1'b1, "range_s1");
    chk("range_s1.state", state_o, READ_S1);
    press(16'h1234, 1'b0, "s1");
    chk("s1.state", state_o, READ_S2);
    press(16'h5678, 1'b0, "s2");
    chk("s2.state", state_o, GUESS);
    chk("s2.player", cur_player, 0);
    press(16'h5687, 1'b0, "p1g");
    chk("p1g.state_score", state_o, SCORE);
    score_wait("p1g");
    chk("p1g.state", state_o, SHOW);
    chk("p1g.bulls", bulls, 2);
    chk("p1g.cows", cows, 2);
    chk("p1g.t1", tries_p1, 1);
    press(16'h0000, 1'b0, "show1");
    chk("show1.state", state_o, GUESS);
    chk("show1.player", cur_player, 1);
    press(16'h1234, 1'b0, "p2g");
    score_wait("p2g");
    chk("p2g.state", state_o, WIN);
    chk("p2g.win", win, 1);
    chk("p2g.winner", winner, 1);
    chk("p2g.bulls", bulls, 4);
    chk("p2g.cows", cows, 0);
    chk("p2g.t2", tries_p2, 1);
    press(16'h5678, 1'b0, "win_hold");
    tick();
    chk("win_hold.state", state_o, WIN);
    chk("win_hold.win", win, 1);

    // ---------------- draw after MAX_TRIES each ----------------
    do_reset();
    press(16'h1234, 1'b0, "d.s1");
    press(16'h5678, 1'b0, "d.s2");
    for (int r = 0; r < MT; r++) begin
      press(16'h1234, 1'b0, "d.p1");
      score_wait("d.p1");
      chk("d.p1.state", state_o, SHOW);
      press(16'h0000, 1'b0, "d.show1");
      chk("d.show1.player", cur_player, 1);
      press(16'h5678, 1'b0, "d.p2");
      score_wait("d.p2");
      chk("d.p2.bc", {bulls, cows}, 0);
      press(16'h0000, 1'b0, "d.show2");
      chk("d.show2.state", state_o, (r == MT - 1) ? DRAW : GUESS);
    end
    chk("draw.flag", draw, 1);
    chk("draw.t1", tries_p1, MT);
    chk("draw.t2", tries_p2, MT);
    chk("draw.win", win, 0);

    // ---------------- held confirm / confirm during SCORE ----------------
    do_reset();
    press(16'h1234, 1'b0, "h.s1");
    press(16'h5678, 1'b0, "h.s2");
    SW = 16'h5687; confirm = 1'b1;
    repeat (20) tick();
    chk("held.state", state_o, SHOW);
    chk("held.t1", tries_p1, 1);
    chk("held.player", cur_player, 0);
    chk("held.bulls", bulls, 2);
    confirm = 1'b0;
    tick();
    chk("held.release", state_o, SHOW);
    press(16'h0000, 1'b0, "h.show");
    chk("h.show.player", cur_player, 1);
    press(16'h4321, 1'b0, "h.p2");
    confirm = 1'b1; tick();
    confirm = 1'b0; tick();
    chk("scorepulse.rv_early", result_valid, 0);
    tick();
    chk("scorepulse.state", state_o, SHOW);
    chk("scorepulse.cows", cows, 4);
    chk("scorepulse.bulls", bulls, 0);
    chk("scorepulse.t2", tries_p2, 1);
    chk("scorepulse.player", cur_player, 1);

    // ---------------- reset during SCORE idx=2 ----------------
    do_reset();
    press(16'h1234, 1'b0, "r.s1");
    press(16'h5678, 1'b0, "r.s2");
    press(16'h5687, 1'b0, "r.g");
    tick();
    chk("r.mid.state", state_o, SCORE);
    reset = 1'b1;
    tick();
    check_idle("midreset");
    reset = 1'b0;
    press(16'h4321, 1'b0, "f.s1");
    press(16'h9870, 1'b0, "f.s2");
    press(16'h0789, 1'b0, "f.g");
    score_wait("f.g");
    chk("fresh.state", state_o, SHOW);
    chk("fresh.bulls", bulls, 0);
    chk("fresh.cows", cows, 4);
    chk("fresh.t1", tries_p1, 1);

    // ---------------- table of P1 guesses against secret 5678 ----------------
    tbl[0] = '{16'h5687, 1'b1, 2, 2};
    tbl[1] = '{16'h8765, 1'b1, 0, 4};
    tbl[2] = '{16'h1234, 1'b1, 0, 0};
    tbl[3] = '{16'h5612, 1'b1, 2, 0};
    tbl[4] = '{16'h0567, 1'b1, 0, 3};
    tbl[5] = '{16'h5678, 1'b1, 4, 0};
    tbl[6] = '{16'h9078, 1'b1, 2, 0};
    tbl[7] = '{16'h1123, 1'b0, 0, 0};
    tbl[8] = '{16'h12A4, 1'b0, 0, 0};
    tbl[9] = '{16'hB123, 1'b0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      press(16'h1234, 1'b0, "t.s1");
      press(16'h5678, 1'b0, "t.s2");
      press(tbl[i].sw, !tbl[i].ok, $sformatf("tbl%0d", i));
      if (tbl[i].ok) begin
        score_wait($sformatf("tbl%0d", i));
        chk($sformatf("tbl%0d.bulls", i), bulls, tbl[i].b);
        chk($sformatf("tbl%0d.cows", i), cows, tbl[i].c);
        chk($sformatf("tbl%0d.state", i), state_o, (tbl[i].b == ND) ? WIN : SHOW);
        chk($sformatf("tbl%0d.t1", i), tries_p1, 1);
      end else begin
        chk($sformatf("tbl%0d.state", i), state_o, GUESS);
        chk($sformatf("tbl%0d.t1", i), tries_p1, 0);
      end
    end

    // ---------------- randomized games against the model ----------------
    for (int g = 0; g < 25; g++) begin
      state_t      ms;
      bit          mp;
      logic [15:0] sec1, sec2, sw;
      int          t1, t2, mb, mc, r;
      bit          ok;
      do_reset();
      ms = READ_S1; mp = 1'b0; sec1 = '0; sec2 = '0;
      t1 = 0; t2 = 0; mb = 0; mc = 0;
      for (int s = 0; s < 16; s++) begin
        r = int'($urandom_range(99, 0));
        if (r < 50)                      sw = rand_perm();
        else if (r < 65 && ms == GUESS)  sw = mp ? sec1 : sec2;
        else                             sw = 16'($urandom);
        ok = m_valid(sw);
        press(sw, ((ms == READ_S1 || ms == READ_S2 || ms == GUESS) && !ok), "rnd");
        case (ms)
          READ_S1: if (ok) begin sec1 = sw; ms = READ_S2; end
          READ_S2: if (ok) begin sec2 = sw; mp = 1'b0; ms = GUESS; end
          GUESS: if (ok) begin
            m_score(sw, mp ? sec1 : sec2, mb, mc);
            if (!mp) t1 = (t1 < MT) ? t1 + 1 : MT;
            else     t2 = (t2 < MT) ? t2 + 1 : MT;
            score_wait("rnd.score");
            ms = (mb == ND) ? WIN : SHOW;
          end
          SHOW: begin
            if (t1 == MT && t2 == MT) ms = DRAW;
            else begin mp = ~mp; ms = GUESS; end
          end
          default: ;
        endcase
        chk("rnd.state", state_o, ms);
        chk("rnd.player", cur_player, mp);
        chk("rnd.bulls", bulls, mb);
        chk("rnd.cows", cows, mc);
        chk("rnd.t1", tries_p1, t1);
        chk("rnd.t2", tries_p2, t2);
        chk("rnd.win", win, (ms == WIN));
        chk("rnd.draw", draw, (ms == DRAW));
        chk("rnd.rv", result_valid, (ms == SHOW || ms == WIN));
        if (ms == WIN) chk("rnd.winner", winner, mp);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bulls_cows_game.md
Name: bulls_cows_game

Overview:
Parametrised two-player Bulls & Cows game controller for the Nexys A7 top level. It captures and validates both secrets and alternates guesses between players. Each guess is scored serially, one digit per cycle, and the block tracks per-player attempt counts with win and draw detection. Results and state feed the LED/7-segment display logic above it.

Parameters:
N_DIGITS, 4, digits per secret/guess (2..8)
DIGIT_W, 4, bits per digit
MAX_DIGIT, 9, largest legal digit value; larger digits are rejected
MAX_TRIES, 10, guesses allowed per player before draw (>=1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; restarts the game
confirm  in  1  debounced confirm button, level; rising edge detected internally
SW  in  N_DIGITS*DIGIT_W  entry; digit i = SW[i*DIGIT_W +: DIGIT_W], digit N_DIGITS-1 leftmost
state_o  out  3  current state (bulls_cows_pkg::state_t)
cur_player  out  1  0 = P1 acting, 1 = P2 acting
bulls  out  $clog2(N_DIGITS+1)  bulls of last scored guess
cows  out  $clog2(N_DIGITS+1)  cows of last scored guess
result_valid  out  1  high while bulls/cows hold a fresh result (SHOW, WIN)
entry_err  out  1  one-cycle pulse on a rejected entry
tries_p1, tries_p2  out  $clog2(MAX_TRIES+1) each  guesses consumed per player
win  out  1  game won
winner  out  1  winning player; valid when win=1
draw  out  1  both players exhausted MAX_TRIES

Behaviour:
- Reset clears all registers. State = READ_S1, cur_player = 0. bulls, cows, tries, win, winner, draw, entry_err and result_valid all 0. Stored secrets and guess are 0. The confirm edge register is cleared.
- Edge detection: cf_edge = confirm & ~confirm_q, where confirm_q is registered every cycle. A held button yields exactly one edge.
- Entry is valid only if all digits are pairwise distinct and every digit is <= MAX_DIGIT (combinational over SW).
- cf_edge with an invalid entry in READ_S1, READ_S2 or GUESS: entry_err pulses 1 cycle the next cycle, and state, secrets and tries are unchanged.
- State machine transitions:
  - READ_S1: on cf_edge with valid entry, store secret1 <= SW, go to READ_S2.
  - READ_S2: on cf_edge with valid entry, store secret2 <= SW, cur_player <= 0, go to GUESS.
  - GUESS: on cf_edge with valid entry, guess_q <= SW, clear bulls/cows accumulators, idx <= 0, increment the acting player's tries, go to SCORE.
  - SCORE: one digit per cycle for idx = 0..N_DIGITS-1. target = secret2 if cur_player=0, else secret1.
    - bull if guess_q digit idx == target digit idx.
    - otherwise cow if it equals any other target digit.
    - After the idx = N_DIGITS-1 cycle, go to SHOW if not a win, or WIN if bulls == N_DIGITS.
    - Latency from accepted cf_edge to result_valid = N_DIGITS+1 cycles.
    - cf_edge during SCORE is ignored, not queued.
  - SHOW: result_valid = 1, bulls/cows stable. On cf_edge:
    - if tries_p1 == MAX_TRIES and tries_p2 == MAX_TRIES, go to DRAW;
    - else toggle cur_player and go to GUESS.
  - WIN: win = 1, winner = cur_player, result_valid = 1. Terminal until reset.
  - DRAW: draw = 1. Terminal until reset.
- Tries counters saturate at MAX_TRIES. Since players strictly alternate, a draw can only occur after P2's guess.
- Reset asserted in any state, including mid-SCORE, takes precedence over every other event in the same cycle.
- bulls + cows <= N_DIGITS always, because the secret has distinct digits.

Decomposition:
- bulls_cows_pkg holds:
  - state_t enum {READ_S1, READ_S2, GUESS, SCORE, SHOW, WIN, DRAW}, logic [2:0];
  - a function digit_at(vec, i);
  - a function entry_valid(vec) parametrised via module parameters passed as arguments.
- One sub-module, bc_entry_check: combinational validity check (distinct + range) over SW, emitting valid. It is reused by the display block for live entry feedback.

Test Plan:
- N_DIGITS=4. Secrets P1 = 1234, P2 = 5678 via clean confirm edges. P1 guesses 5687 -> 5 cycles later result_valid=1, bulls=2, cows=2, tries_p1=1, state SHOW.
- In READ_S1, SW=1123 and confirm -> entry_err 1-cycle pulse, state stays READ_S1. SW=12A4 (digit 10 > MAX_DIGIT) -> same response.
- After P1's SHOW, confirm -> cur_player=1. P2 guesses 1234 -> win=1, winner=1, bulls=4, cows=0. Further confirms leave state WIN.
- MAX_TRIES=2, no correct guesses -> after P2's second guess and a SHOW confirm, draw=1, tries_p1=tries_p2=2.
- Confirm held high for 20 cycles in GUESS -> exactly one guess scored, tries increments by 1. Confirm pulsed during SCORE -> ignored.
- Reset asserted on SCORE cycle idx=2 -> next cycle state READ_S1 and all outputs 0. A fresh game then proceeds normally.
